// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ requesters into one FIFO write port.
// Packet locking is built only with FIFO_ARB_PACKET_LOCK_EN defined.
module fifo_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LOG_NUM_REQ = 2,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [DATA_WIDTH+LOG_NUM_REQ-1:0] fifo_data_write,
  output logic                            fifo_write,
  input  logic                            fifo_full,
  input  logic                            fifo_almost_full,
  output logic                            locked
);

  localparam int IW = LOG_NUM_REQ;
  localparam logic [IW:0]   NREQ     = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ-1);

  logic                  room;
  logic                  hit;
  logic                  accept;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         gidx;
  logic [IW-1:0]         cand_idx;
  logic [IW-1:0]         nxt_ptr;
  logic [IW:0]           cand;
  logic [DATA_WIDTH-1:0] sel_data;

`ifdef FIFO_ARB_PACKET_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;
  state_t        state;
  logic [IW-1:0] owner;
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign locked      = 1'b0;
`endif

  // A registered write into the last free slot leaves no room this cycle.
  assign room = ~fifo_full & ~(fifo_almost_full & fifo_write);

  always_comb begin
    hit      = 1'b0;
    gidx     = '0;
    cand     = '0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = cand[IW-1:0];
      if (!hit && req_valid[cand_idx]) begin
        hit  = 1'b1;
        gidx = cand_idx;
      end
    end
`ifdef FIFO_ARB_PACKET_LOCK_EN
    if (state == LOCKED) begin
      hit  = req_valid[owner];
      gidx = owner;
    end
`endif
  end

  assign accept  = hit & room & rst;
  assign nxt_ptr = (gidx == LAST_IDX) ? '0 : gidx + IW'(1);

  always_comb begin
    req_ready = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == IW'(i)) begin
        req_ready[i] = accept;
        sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr          <= '0;
      fifo_write      <= 1'b0;
      fifo_data_write <= '0;
`ifdef FIFO_ARB_PACKET_LOCK_EN
      state           <= ARB;
      owner           <= '0;
      locked          <= 1'b0;
`endif
    end else begin
      fifo_write <= accept;
      if (accept) begin
        fifo_data_write <= {gidx, sel_data};
`ifdef FIFO_ARB_PACKET_LOCK_EN
        if (state == ARB && !req_last[gidx]) begin
          state  <= LOCKED;
          owner  <= gidx;
          locked <= 1'b1;
        end else if (req_last[gidx]) begin
          state  <= ARB;
          locked <= 1'b0;
          rr_ptr <= nxt_ptr;
        end
`else
        rr_ptr <= nxt_ptr;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter; lock sequences follow
// FIFO_ARB_PACKET_LOCK_EN so the bench matches either build.
module tb_fifo_write_arbiter;

`ifdef FIFO_ARB_PACKET_LOCK_EN
  localparam logic LOCK = 1'b1;
`else
  localparam logic LOCK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [9:0]  fifo_data_write;
  logic        fifo_write;
  logic        fifo_full;
  logic        fifo_almost_full;
  logic        locked;

  int checks = 0;
  int errors = 0;

  fifo_write_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_last         (req_last),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_data_write  (fifo_data_write),
    .fifo_write       (fifo_write),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .locked           (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rb;
    logic [3:0] v;
    logic [3:0] l;
    logic       f;
    logic       af;
    logic [3:0] er;
    logic       ew;
    logic [9:0] ed;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [9:0] fd(input int i);
    logic [1:0] ii;
    logic [7:0] b;
    ii = i[1:0];
    b  = 8'hA0 + 8'h11 * 8'(ii);
    return {ii, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic step(input string name, input logic [3:0] v,
                      input logic [3:0] l, input logic f, input logic af,
                      input logic [3:0] er, input logic ew,
                      input logic [9:0] ed, input logic el);
    req_valid        = v;
    req_last         = l;
    fifo_full        = f;
    fifo_almost_full = af;
    #1;
    chk({name, " ready"}, 32'(req_ready), 32'(er));
    @(posedge clk);
    #1;
    chk({name, " write"}, 32'(fifo_write), 32'(ew));
    chk({name, " data"}, 32'(fifo_data_write), 32'(ed));
    chk({name, " locked"}, 32'(locked), 32'(el));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, fd(0)};
    tbl[1]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, fd(1)};
    tbl[2]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, fd(2)};
    tbl[3]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, fd(3)};
    tbl[4]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, fd(0)};
    tbl[5]  = '{1'b1, 4'b1010, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, fd(1)};
    tbl[6]  = '{1'b0, 4'b1010, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, fd(3)};
    tbl[7]  = '{1'b0, 4'b1010, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, fd(1)};
    tbl[8]  = '{1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, fd(1)};
    tbl[9]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0100, 1'b1, fd(2)};
    tbl[10] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, fd(2)};
    tbl[11] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, fd(3)};
    tbl[12] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, fd(0)};
    tbl[13] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, fd(0)};
    tbl[14] = '{1'b0, 4'b0100, 4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, fd(2)};
    tbl[15] = '{1'b0, 4'b0011, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, fd(0)};

    rst              = 1'b0;
    req_valid        = 4'b1111;
    req_last         = 4'b1111;
    req_data         = {fd(3)[7:0], fd(2)[7:0], fd(1)[7:0], fd(0)[7:0]};
    fifo_full        = 1'b0;
    fifo_almost_full = 1'b0;
    #1;
    chk("reset ready", 32'(req_ready), 32'h0);
    chk("reset write", 32'(fifo_write), 32'h0);
    chk("reset data", 32'(fifo_data_write), 32'h0);
    chk("reset locked", 32'(locked), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rb) do_reset();
      step($sformatf("vec%0d", i), tbl[i].v, tbl[i].l, tbl[i].f,
           tbl[i].af, tbl[i].er, tbl[i].ew, tbl[i].ed, 1'b0);
    end

`ifdef FIFO_ARB_PACKET_LOCK_EN
    do_reset();
    step("pkt pre",  4'b0010, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, fd(1), 1'b0);
    step("pkt b1",   4'b0101, 4'b0001, 1'b0, 1'b0, 4'b0100, 1'b1, fd(2), 1'b1);
    step("pkt b2",   4'b0101, 4'b0001, 1'b0, 1'b0, 4'b0100, 1'b1, fd(2), 1'b1);
    step("pkt b3",   4'b0101, 4'b0101, 1'b0, 1'b0, 4'b0100, 1'b1, fd(2), 1'b0);
    step("pkt nxt",  4'b0101, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, fd(0), 1'b0);
    do_reset();
    step("own b1",   4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, fd(1), 1'b1);
    step("own gap1", 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, fd(1), 1'b1);
    step("own gap2", 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, fd(1), 1'b1);
    step("own end",  4'b0011, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, fd(1), 1'b0);
    step("own nxt",  4'b0001, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, fd(0), 1'b0);
`else
    do_reset();
    step("nolock a", 4'b0101, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, fd(0), 1'b0);
    step("nolock b", 4'b0101, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, fd(2), 1'b0);
    step("nolock c", 4'b0101, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, fd(0), 1'b0);
`endif

    do_reset();
    step("mid pkt", 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, fd(1), LOCK);
    req_valid = 4'b0011;
    #2;
    rst = 1'b0;
    #1;
    chk("mid rst write", 32'(fifo_write), 32'h0);
    chk("mid rst locked", 32'(locked), 32'h0);
    chk("mid rst ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("in rst ready", 32'(req_ready), 32'h0);
    chk("in rst write", 32'(fifo_write), 32'h0);
    rst = 1'b1;
    step("post rst", 4'b0011, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, fd(0), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
